// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART blocks: FSM states, defaults,
// the line idle level and the oversample-tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    localparam int   DATA_BITS_DEF = 8;
    localparam logic LINE_IDLE     = 1'b1;

    // Clocks per oversample tick; never below one so the divider always advances.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks, restartable by clr
// so the sampling phase can be aligned to an incoming edge.
module uart_os_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with start/stop validation, break
// handling and a one-entry valid/ready holding register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 rx_en,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] MID_T  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rx_s;
    logic                 tick;
    logic                 start_det;
    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_done;
    logic                 stop_good;

    // NOTE: synchronizer resets to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= LINE_IDLE;
            rx_s  <= LINE_IDLE;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    assign start_det = (state == IDLE) && rx_en && (rx_s != LINE_IDLE);

    uart_os_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            stop_done <= 1'b0;
            stop_good <= 1'b0;
        end else begin
            stop_done <= 1'b0;
            // Disabling the receiver abandons any frame in flight without flags.
            if (state != IDLE && !rx_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_det) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (tick_cnt == MID_T) begin
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                                state    <= (rx_s == LINE_IDLE) ? IDLE : DATA;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (tick_cnt == LAST_T) begin
                                tick_cnt       <= '0;
                                shift[bit_idx] <= rx_s;
                                if (bit_idx == LAST_B) begin
                                    state <= STOP;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (tick_cnt == LAST_T) begin
                                tick_cnt  <= '0;
                                stop_done <= 1'b1;
                                stop_good <= rx_s;
                                state     <= (rx_s == LINE_IDLE) ? IDLE : BREAK_WAIT;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    BREAK_WAIT: begin
                        // A held-low line must return high before a new start is armed.
                        if (rx_s == LINE_IDLE) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Holding register: a finished frame loads only if the slot is empty or draining now.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_done && !stop_good;
            overrun   <= 1'b0;
            if (stop_done && stop_good) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus randomized frames,
// compared every cycle against a frame-level model of the holding register.
module tb_uart_rx_os;

    localparam int BIT_CLKS  = 16;
    localparam int NBITS     = 8;
    localparam int SYNC_LAT  = 3;    // two synchronizer flops plus the detecting edge
    localparam int STOP_LAT  = 153;  // start detection to output update

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_en = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_os #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_en      (rx_en),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         good;
    } frame_t;

    frame_t     pend[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    bit         mon_en = 1'b0;
    bit         rand_ready = 1'b0;
    int         busy_rise = 0;
    int         dv_rise = 0;
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;
    int         xfer_cnt = 0;
    logic       prev_busy = 1'b0;
    logic       prev_dv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame-level reference: a completed frame lands STOP_LAT edges after detection.
    always @(posedge clk) begin : model
        frame_t f;
        bit     fire;
        cyc++;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        fire   = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            f    = pend.pop_front();
            fire = 1'b1;
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
        end else begin
            if (fire && f.good) begin
                if (!m_valid || data_ready) begin
                    m_data  = f.data;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
            if (fire && !f.good) m_ferr = 1'b1;
        end
    end

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check("data_valid", data_valid, m_valid);
            check("data_out", data_out, m_data);
            check("frame_err", frame_err, m_ferr);
            check("overrun", overrun, m_ovr);
            if (busy && !prev_busy) busy_rise = cyc;
            if (data_valid && !prev_dv) dv_rise = cyc;
            if (overrun) ovr_cnt++;
            if (frame_err) ferr_cnt++;
            if (data_valid && data_ready) xfer_cnt++;
            prev_busy = busy;
            prev_dv   = data_valid;
        end
    end

    always @(negedge clk) begin
        if (rand_ready) data_ready = ($urandom_range(0, 2) == 0);
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    // Drives one frame; abort_at >= 0 aborts mid-bit (rst or rx_en=0, held by caller).
    task automatic send_frame(input logic [7:0] b, input bit stop_val, input bit expect_it,
                              input int abort_at, input bit use_rst);
        frame_t f;
        @(negedge clk);
        f.due  = cyc + SYNC_LAT + STOP_LAT;
        f.data = b;
        f.good = stop_val;
        if (expect_it) pend.push_back(f);
        rx_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < NBITS; i++) begin
            rx_in = b[i];
            for (int k = 0; k < BIT_CLKS; k++) begin
                if (i == abort_at && k == 8) begin
                    if (use_rst) rst = 1'b1;
                    else rx_en = 1'b0;
                end
                @(negedge clk);
                if (i == abort_at && k == 8) check("abort_to_idle", busy, 1'b0);
            end
        end
        rx_in = stop_val;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check("drain_clears", data_valid, 1'b0);
    endtask

    initial begin
        int         f0;
        int         o0;
        int         x0;
        int         nbad;
        logic [7:0] rb;
        bit         bad;

        repeat (4) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_valid", data_valid, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Basic frame and latency from start detection.
        send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
        check("a5_valid", data_valid, 1'b1);
        check("a5_data", data_out, 8'hA5);
        check("a5_latency", dv_rise - busy_rise, STOP_LAT);
        check("a5_no_ferr", ferr_cnt, 0);
        check("a5_no_ovr", ovr_cnt, 0);
        drain();

        // Framing error followed by a held-low line.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
        repeat (40) @(negedge clk);
        check("break_busy", busy, 1'b1);
        check("break_ferr_once", ferr_cnt - f0, 1);
        check("break_no_valid", data_valid, 1'b0);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("break_release", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1, -1, 1'b0);
        check("after_break_valid", data_valid, 1'b1);
        check("after_break_data", data_out, 8'h81);
        drain();

        // Short glitch is rejected at the mid-start sample.
        @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        check("glitch_started", busy, 1'b1);
        repeat (20) @(negedge clk);
        check("glitch_idle", busy, 1'b0);
        check("glitch_no_valid", data_valid, 1'b0);

        // Overrun keeps the first byte.
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, -1, 1'b0);
        check("ovr_data_kept", data_out, 8'h11);
        check("ovr_pulse", ovr_cnt - o0, 1);
        drain();

        // Continuous ready across back-to-back frames.
        o0 = ovr_cnt;
        x0 = xfer_cnt;
        data_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        data_ready = 1'b0;
        check("b2b_xfers", xfer_cnt - x0, 2);
        check("b2b_no_ovr", ovr_cnt - o0, 0);
        check("b2b_last", data_out, 8'hAA);

        // Reset mid-frame clears the holding register.
        rb = 8'($urandom);
        send_frame(rb, 1'b1, 1'b1, -1, 1'b0);
        check("pre_rst_valid", data_valid, 1'b1);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'hF0, 1'b1, 1'b0, 3, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_valid", data_valid, 1'b0);
        check("rst_abort_data", data_out, 8'h00);
        check("rst_abort_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        send_frame(8'h0F, 1'b1, 1'b1, -1, 1'b0);
        check("post_rst_data", data_out, 8'h0F);

        // Receiver disable mid-frame leaves the holding register alone.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'hF0, 1'b1, 1'b0, 3, 1'b0);
        @(negedge clk);
        rx_en = 1'b1;
        @(negedge clk);
        check("en_abort_busy", busy, 1'b0);
        check("en_abort_valid", data_valid, 1'b1);
        check("en_abort_data", data_out, 8'h0F);
        check("en_abort_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        drain();
        send_frame(8'h0F, 1'b1, 1'b1, -1, 1'b0);
        check("post_en_data", data_out, 8'h0F);
        drain();

        // Random frames, random stop errors, random consumer.
        f0   = ferr_cnt;
        nbad = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            if (bad) nbad++;
            send_frame(rb, !bad, 1'b1, -1, 1'b0);
            rx_in = 1'b1;
            repeat (2 + $urandom_range(0, 11)) @(negedge clk);
        end
        rand_ready = 1'b0;
        @(negedge clk);
        data_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("rand_ferr_count", ferr_cnt - f0, nbad);
        check("rand_idle", busy, 1'b0);

        mon_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver. It is the receive end for the existing serial transmitter.
- Runs on the system clock with an internal oversample-tick divider, instead of consuming a pre-divided baud pulse.
- Recovers 8N1 frames from an asynchronous rx line, validates the start and stop bits, and presents bytes through a one-entry valid/ready holding register.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit period. Must be even and ≥4.
- DATA_BITS, 8: payload bits per frame, sent LSB first.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idles high.
- rx_en  in  1  receiver enable.
- data_ready  in  1  consumer accepts data_out this cycle.
- data_out  out  DATA_BITS  received byte; held stable while data_valid=1.
- data_valid  out  1  holding register is full.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a frame completed while the holding register was full and not being drained.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0, state goes to IDLE.
  - Synchronizer flops go to 1; tick divider and bit counter go to 0.
- rx_in passes through a 2-FF synchronizer; rx_s is the second-stage output. Detection latency is 2 clk.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, minimum 1.
  - tick pulses one cycle every DIV clks.
  - The divider is cleared on start detection so the sampling phase aligns to the falling edge.
- State machine:
  - IDLE: if rx_en=1 and rx_s=0, go to START; clear tick_cnt and divider.
  - START: count ticks. At tick OVERSAMPLE/2 (mid-bit), sample rx_s. If 0, go to DATA with bit_idx=0 and tick_cnt=0. If 1, it was a false start (glitch): go to IDLE with no flags.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into bit position bit_idx (LSB first). After bit DATA_BITS-1 is sampled, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: good frame. Deliver it (see handshake) and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s=1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- Timing, with start detection in cycle T:
  - The stop bit is sampled at tick 8+16*9 = 152 (OVERSAMPLE=16, DATA_BITS=8).
  - data_valid, frame_err or overrun update in the cycle after the stop sample.
- Valid/ready handshake:
  - Transfer happens when data_valid=1 and data_ready=1 at a clk edge. data_valid clears next cycle unless a new byte loads on the same edge.
  - Good frame with data_valid=0, or data_valid=1 with data_ready=1 on the same edge: load data_out and set data_valid=1. No overrun.
  - Good frame with data_valid=1 and data_ready=0: keep the old data, drop the new byte, pulse overrun.
  - data_ready while data_valid=0 has no effect.
- rx_en=0:
  - In IDLE, start detection is blocked.
  - In any other state, the FSM aborts to IDLE on the next edge with no flags. The holding register is unaffected.
- Reset mid-frame: abort immediately; the holding register and data_valid are cleared.
- Counters are sized by $clog2 of OVERSAMPLE, DATA_BITS and DIV. No wrap occurs inside a frame.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, BREAK_WAIT.
  - DATA_BITS default.
  - Constant function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
  - Line idle level constant (1).
- Sub-module uart_os_tick_gen: the divider, with inputs clk, rst, clr and output tick. It is reusable by a future oversampled transmitter.

Test Plan:
- Use CLK_FREQ=1_600_000, BAUD=100_000 (DIV=1, 16 clk/bit).
- Frame 0xA5, rx_en=1, data_ready=0 -> data_out=0xA5, data_valid=1 at T+153 (T = start detection). frame_err=0, overrun=0.
- Frame 0x3C with stop bit forced low, line then held low for 40 clk -> frame_err pulses once, data_valid stays 0. No new start is detected until rx high; a following 0x81 frame is received correctly.
- Glitch: rx low for 4 clk, then high -> false start, busy drops back to 0, no data_valid.
- Frames 0x11 then 0x22 with data_ready=0 -> data_out=0x11, overrun pulses at the end of the second frame. Raising data_ready -> data_valid clears next cycle.
- data_ready held 1 across back-to-back 0x55 and 0xAA frames -> two transfers, no overrun.
- rst or rx_en=0 asserted in DATA at bit 3 of 0xF0 -> FSM goes to IDLE, no flags. With rst, data_valid=0. A subsequent 0x0F frame is received correctly.
